// File: rtl/regfile_pkg.sv
// Shared defaults and writeback source indices for the register-file
// writeback scheduler and its round-robin arbiter.
package regfile_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_DEPTH_LOG2 = 4;

  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;

endpackage

// File: rtl/regfile_wb_sched_rr_arb2.sv
// Two-requester round-robin arbiter; owns the "last granted" pointer.
// r_last_lsu = 1 means wb1 (LSU) was granted last, so wb0 wins the next tie.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_last_lsu;

  always_comb begin
    o_grant = '0;
    case (i_req)
      2'b01:   o_grant[SRC_ALU] = 1'b1;
      2'b10:   o_grant[SRC_LSU] = 1'b1;
      2'b11: begin
        if (r_last_lsu) o_grant[SRC_ALU] = 1'b1;
        else            o_grant[SRC_LSU] = 1'b1;
      end
      default: o_grant = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_lsu <= 1'b1;
    end else if (i_accept) begin
      r_last_lsu <= o_grant[SRC_LSU];
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: arbitrates ALU/LSU writebacks onto one registered
// register-file write port and tracks in-flight destinations for RAW hazards.
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [DEPTH_LOG2-1:0] issue_rd,
  output logic                  issue_stall,
  input  logic [DEPTH_LOG2-1:0] rs1_addr,
  output logic                  rs1_busy,
  input  logic [DEPTH_LOG2-1:0] rs2_addr,
  output logic                  rs2_busy,
  input  logic                  wb0_valid,
  input  logic [DEPTH_LOG2-1:0] wb0_addr,
  input  logic [WIDTH-1:0]      wb0_data,
  output logic                  wb0_ready,
  input  logic                  wb1_valid,
  input  logic [DEPTH_LOG2-1:0] wb1_addr,
  input  logic [WIDTH-1:0]      wb1_data,
  output logic                  wb1_ready,
  output logic                  rd_write,
  output logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_wdata,
  output logic                  idle
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Handshake: a writeback transfers on the rising edge where wbN_valid and
  // wbN_ready are both high; the source holds valid/addr/data until then.
  logic [1:0]            w_grant;
  logic                  w_xfer;
  logic [DEPTH_LOG2-1:0] w_addr;
  logic [WIDTH-1:0]      w_data;

  logic [DEPTH-1:0]      r_busy;
  logic [DEPTH-1:0]      w_set;
  logic [DEPTH-1:0]      w_clr;
  logic [DEPTH-1:0]      w_busy_nxt;

  logic                  r_rd_write;
  logic [DEPTH_LOG2-1:0] r_rd_addr;
  logic [WIDTH-1:0]      r_rd_wdata;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    ({wb1_valid, wb0_valid}),
    .i_accept (w_xfer),
    .o_grant  (w_grant)
  );

  assign wb0_ready = w_grant[SRC_ALU];
  assign wb1_ready = w_grant[SRC_LSU];
  assign w_xfer    = |w_grant;
  assign w_addr    = w_grant[SRC_LSU] ? wb1_addr : wb0_addr;
  assign w_data    = w_grant[SRC_LSU] ? wb1_data : wb0_data;

  // x0 writes are accepted but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_write <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_wdata <= '0;
    end else if (w_xfer) begin
      r_rd_write <= (w_addr != '0);
      r_rd_addr  <= w_addr;
      r_rd_wdata <= w_data;
    end else begin
      r_rd_write <= 1'b0;
    end
  end

  assign issue_stall = issue_valid & r_busy[issue_rd];
  assign rs1_busy    = r_busy[rs1_addr];
  assign rs2_busy    = r_busy[rs2_addr];

  // Set beats clear on the same entry; bit 0 is forced low.
  assign w_set      = (issue_valid && !issue_stall) ? (DEPTH'(1) << issue_rd) : '0;
  assign w_clr      = r_rd_write ? (DEPTH'(1) << r_rd_addr) : '0;
  assign w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~DEPTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign rd_write = r_rd_write;
  assign rd_addr  = r_rd_addr;
  assign rd_wdata = r_rd_wdata;
  assign idle     = ~(|r_busy) & ~r_rd_write;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: handshake, arbitration, scoreboard
// and asynchronous reset, with hand-computed expectations.
module tb_regfile_wb_sched;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [3:0]  issue_rd;
  logic        issue_stall;
  logic [3:0]  rs1_addr;
  logic        rs1_busy;
  logic [3:0]  rs2_addr;
  logic        rs2_busy;
  logic        wb0_valid;
  logic [3:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb0_ready;
  logic        wb1_valid;
  logic [3:0]  wb1_addr;
  logic [31:0] wb1_data;
  logic        wb1_ready;
  logic        rd_write;
  logic [3:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        idle;

  int errors;
  int checks;

  regfile_wb_sched #(.WIDTH(32), .DEPTH_LOG2(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_stall (issue_stall),
    .rs1_addr    (rs1_addr),
    .rs1_busy    (rs1_busy),
    .rs2_addr    (rs2_addr),
    .rs2_busy    (rs2_busy),
    .wb0_valid   (wb0_valid),
    .wb0_addr    (wb0_addr),
    .wb0_data    (wb0_data),
    .wb0_ready   (wb0_ready),
    .wb1_valid   (wb1_valid),
    .wb1_addr    (wb1_addr),
    .wb1_data    (wb1_data),
    .wb1_ready   (wb1_ready),
    .rd_write    (rd_write),
    .rd_addr     (rd_addr),
    .rd_wdata    (rd_wdata),
    .idle        (idle)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = '0;
    rs1_addr = '0; rs2_addr = '0;
    wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle_inputs();
    do_reset();
    settle();

    // Reset state
    check("rst_rd_write", 32'(rd_write), 32'd0);
    check("rst_rd_addr",  32'(rd_addr),  32'd0);
    check("rst_rd_wdata", rd_wdata,      32'd0);
    check("rst_idle",     32'(idle),     32'd1);
    check("rst_wb0_ready",32'(wb0_ready),32'd0);

    // wb0 writes x5 = DEADBEEF
    tick();
    wb0_valid = 1'b1; wb0_addr = 4'd5; wb0_data = 32'hDEADBEEF;
    settle();
    check("x5_wb0_ready", 32'(wb0_ready), 32'd1);
    check("x5_wb1_ready", 32'(wb1_ready), 32'd0);
    tick();
    wb0_valid = 1'b0;
    settle();
    check("x5_rd_write", 32'(rd_write), 32'd1);
    check("x5_rd_addr",  32'(rd_addr),  32'd5);
    check("x5_rd_wdata", rd_wdata,      32'hDEADBEEF);
    check("x5_idle_busy_write", 32'(idle), 32'd0);
    tick();
    settle();
    check("x5_write_drop", 32'(rd_write), 32'd0);
    check("x5_addr_hold",  32'(rd_addr),  32'd5);
    check("x5_data_hold",  rd_wdata,      32'hDEADBEEF);

    // Dual contention from reset pointer: wb0, wb1, wb0, wb1
    do_reset();
    wb0_valid = 1'b1; wb0_addr = 4'd1; wb0_data = 32'h0000_0011;
    wb1_valid = 1'b1; wb1_addr = 4'd2; wb1_data = 32'h0000_0022;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("rr%0d_wb0_ready", i), 32'(wb0_ready), 32'((i % 2) == 0));
      check($sformatf("rr%0d_wb1_ready", i), 32'(wb1_ready), 32'((i % 2) == 1));
      tick();
      check($sformatf("rr%0d_rd_addr", i), 32'(rd_addr), ((i % 2) == 0) ? 32'd1 : 32'd2);
      check($sformatf("rr%0d_rd_wdata", i), rd_wdata,
            ((i % 2) == 0) ? 32'h0000_0011 : 32'h0000_0022);
    end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    tick();

    // Issue x7, hazard on rs1, second issue stalls, clear on write edge
    issue_valid = 1'b1; issue_rd = 4'd7;
    settle();
    check("x7_issue_no_stall", 32'(issue_stall), 32'd0);
    tick();
    issue_valid = 1'b0; rs1_addr = 4'd7;
    settle();
    check("x7_rs1_busy", 32'(rs1_busy), 32'd1);
    check("x7_idle", 32'(idle), 32'd0);
    issue_valid = 1'b1; issue_rd = 4'd7;
    settle();
    check("x7_reissue_stall", 32'(issue_stall), 32'd1);
    tick();
    issue_valid = 1'b0;
    wb1_valid = 1'b1; wb1_addr = 4'd7; wb1_data = 32'h0000_0077;
    settle();
    check("x7_wb1_ready", 32'(wb1_ready), 32'd1);
    tick();
    wb1_valid = 1'b0;
    settle();
    check("x7_rd_write", 32'(rd_write), 32'd1);
    check("x7_busy_until_edge", 32'(rs1_busy), 32'd1);
    tick();
    settle();
    check("x7_busy_cleared", 32'(rs1_busy), 32'd0);
    check("x7_idle_after", 32'(idle), 32'd1);

    // Issue x3 on the edge its writeback clears: set wins
    wb0_valid = 1'b1; wb0_addr = 4'd3; wb0_data = 32'h0000_0033;
    tick();
    wb0_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 4'd3; rs2_addr = 4'd3;
    settle();
    check("x3_rd_write", 32'(rd_write), 32'd1);
    check("x3_rd_addr", 32'(rd_addr), 32'd3);
    check("x3_no_stall", 32'(issue_stall), 32'd0);
    tick();
    issue_valid = 1'b0;
    settle();
    check("x3_set_wins", 32'(rs2_busy), 32'd1);
    wb0_valid = 1'b1;
    tick();
    wb0_valid = 1'b0;
    tick();
    settle();
    check("x3_cleared", 32'(rs2_busy), 32'd0);

    // wb1 writes x0: accepted, no register-file write, idle stays high
    wb1_valid = 1'b1; wb1_addr = 4'd0; wb1_data = 32'h0000_1234;
    issue_valid = 1'b1; issue_rd = 4'd0; rs1_addr = 4'd0;
    settle();
    check("x0_wb1_ready", 32'(wb1_ready), 32'd1);
    check("x0_issue_no_stall", 32'(issue_stall), 32'd0);
    tick();
    wb1_valid = 1'b0; issue_valid = 1'b0;
    settle();
    check("x0_rd_write", 32'(rd_write), 32'd0);
    check("x0_rd_wdata", rd_wdata, 32'h0000_1234);
    check("x0_rs1_busy", 32'(rs1_busy), 32'd0);
    check("x0_idle", 32'(idle), 32'd1);

    // Asynchronous reset with busy[4]=1 and rd_write=1
    issue_valid = 1'b1; issue_rd = 4'd4; rs1_addr = 4'd4;
    tick();
    issue_valid = 1'b0;
    wb0_valid = 1'b1; wb0_addr = 4'd9; wb0_data = 32'h0000_0099;
    tick();
    wb0_valid = 1'b0;
    settle();
    check("ar_pre_rd_write", 32'(rd_write), 32'd1);
    check("ar_pre_busy4", 32'(rs1_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_rd_write", 32'(rd_write), 32'd0);
    check("ar_rd_addr",  32'(rd_addr),  32'd0);
    check("ar_rd_wdata", rd_wdata,      32'd0);
    check("ar_busy4",    32'(rs1_busy), 32'd0);
    check("ar_idle",     32'(idle),     32'd1);
    // Pointer was "wb0 last" before reset; reset must restore "wb1 last"
    wb0_valid = 1'b1; wb0_addr = 4'd1;
    wb1_valid = 1'b1; wb1_addr = 4'd2;
    #1;
    check("ar_ptr_wb0_ready", 32'(wb0_ready), 32'd1);
    check("ar_ptr_wb1_ready", 32'(wb1_ready), 32'd0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
